// File: rtl/qnigma_math_chacha20_kst_fifo.sv
// ChaCha20 keystream prefetch FIFO: requests 512-bit blocks, serialises them into a block RAM and
// hands out WIDTH-bit words in order, with flush/rekey discard, block skip and underflow flag.
module qnigma_math_chacha20_kst_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLKS  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    output logic                                     blk_nxt,
    input  logic                                     blk_run,
    input  logic [511:0]                             blk_kst,
    input  logic                                     blk_val,
    output logic                                     rdy,
    input  logic                                     read,
    input  logic                                     skip,
    output logic [WIDTH-1:0]                         str,
    output logic                                     str_val,
    output logic [$clog2(BLKS*(512/WIDTH)):0]        lvl,
    output logic                                     err
);

    localparam int unsigned WPB   = 512 / WIDTH;
    localparam int unsigned DEPTH = BLKS * WPB;
    localparam int unsigned WW    = $clog2(WPB);
    localparam int unsigned BW    = $clog2(BLKS);
    localparam int unsigned PW    = BW + 1;
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WW-1:0]    rd_word_q, rd_word_d;
    logic             ser_act_q, ser_act_d;
    logic [WW-1:0]    ser_cnt_q, ser_cnt_d;
    logic [511:0]     ser_data_q, ser_data_d;
    logic             infl_q, infl_d;
    logic             discard_q, discard_d;
    logic             nxt_q, nxt_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic [WIDTH-1:0] str_q, str_d;
    logic             str_val_q, str_val_d;
    logic             err_q, err_d;

    logic [PW-1:0]    used;
    logic             rdy_int;
    logic             rd_ok;
    logic             skip_ok;
    logic             commit;
    logic [LW-1:0]    consumed;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;

    assign rdy_int   = (lvl_q != '0);
    assign used      = wr_q - rd_q;
    assign rd_ok     = read && rdy_int && !flush;
    assign skip_ok   = skip && rdy_int && !flush;
    assign commit    = ser_act_q && (ser_cnt_q == WW'(WPB - 1));
    assign mem_we    = ser_act_q && !flush && !rst;
    assign mem_waddr = {wr_q[BW-1:0], ser_cnt_q};
    assign mem_raddr = {rd_q[BW-1:0], rd_word_q};

    always_comb begin
        if (skip_ok) begin
            // Skip consumes everything left in the current block, including a same-cycle read.
            consumed = LW'(WPB) - LW'(rd_word_q);
        end else if (rd_ok) begin
            consumed = LW'(1);
        end else begin
            consumed = '0;
        end
    end

    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        rd_word_d  = rd_word_q;
        ser_act_d  = ser_act_q;
        ser_cnt_d  = ser_cnt_q;
        ser_data_d = ser_data_q;
        infl_d     = infl_q;
        discard_d  = discard_q;
        lvl_d      = lvl_q;
        str_val_d  = rd_ok;
        str_d      = rd_ok ? mem[mem_raddr] : '0;
        err_d      = read && !rdy_int && !flush;

        if (flush) begin
            wr_d      = '0;
            rd_d      = '0;
            rd_word_d = '0;
            ser_act_d = 1'b0;
            ser_cnt_d = '0;
            lvl_d     = '0;
            if (blk_val && infl_q) begin
                infl_d    = 1'b0;
                discard_d = 1'b0;
            end else if (infl_q || nxt_q) begin
                // A block of the old key is still coming; swallow it when it lands.
                infl_d    = 1'b1;
                discard_d = 1'b1;
            end
        end else begin
            if (ser_act_q) begin
                ser_cnt_d  = ser_cnt_q + WW'(1);
                ser_data_d = ser_data_q >> WIDTH;
                if (commit) begin
                    ser_act_d = 1'b0;
                    wr_d      = wr_q + PW'(1);
                end
            end
            if (skip_ok || (rd_ok && rd_word_q == WW'(WPB - 1))) begin
                rd_word_d = '0;
                rd_d      = rd_q + PW'(1);
            end else if (rd_ok) begin
                rd_word_d = rd_word_q + WW'(1);
            end
            lvl_d = lvl_q + (commit ? LW'(WPB) : LW'(0)) - consumed;
            if (blk_val && infl_q) begin
                infl_d    = 1'b0;
                discard_d = 1'b0;
                if (!discard_q) begin
                    ser_act_d  = 1'b1;
                    ser_cnt_d  = '0;
                    ser_data_d = blk_kst;
                end
            end
            if (nxt_q) begin
                infl_d = 1'b1;
            end
        end

        // Serialising block counts as occupied so the RAM can never be over-requested.
        nxt_d = ({1'b0, used} + CW'(infl_q) + CW'(ser_act_q) < CW'(BLKS))
                && !blk_run && !infl_q && !nxt_q && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            rd_word_q  <= '0;
            ser_act_q  <= 1'b0;
            ser_cnt_q  <= '0;
            ser_data_q <= '0;
            infl_q     <= 1'b0;
            discard_q  <= 1'b0;
            nxt_q      <= 1'b0;
            lvl_q      <= '0;
            str_q      <= '0;
            str_val_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_word_q  <= rd_word_d;
            ser_act_q  <= ser_act_d;
            ser_cnt_q  <= ser_cnt_d;
            ser_data_q <= ser_data_d;
            infl_q     <= infl_d;
            discard_q  <= discard_d;
            nxt_q      <= nxt_d;
            lvl_q      <= lvl_d;
            str_q      <= str_d;
            str_val_q  <= str_val_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= ser_data_q[WIDTH-1:0];
        end
    end

    assign blk_nxt = nxt_q;
    assign rdy     = rdy_int;
    assign str     = str_q;
    assign str_val = str_val_q;
    assign lvl     = lvl_q;
    assign err     = err_q;

endmodule

// File: tb/tb_qnigma_math_chacha20_kst_fifo.sv
// Bench for the keystream FIFO: a 20-cycle-latency generator model feeds random blocks, and a
// queue-of-words reference model predicts level, ready, read data and error pulses.
module tb_qnigma_math_chacha20_kst_fifo;

    localparam int W       = 64;
    localparam int BLKS    = 4;
    localparam int WPB     = 512 / W;
    localparam int LW      = $clog2(BLKS * WPB) + 1;
    localparam int GEN_LAT = 20;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          blk_nxt;
    logic          blk_run;
    logic [511:0]  blk_kst;
    logic          blk_val;
    logic          rdy;
    logic          read;
    logic          skip;
    logic [W-1:0]  str;
    logic          str_val;
    logic [LW-1:0] lvl;
    logic          err;

    qnigma_math_chacha20_kst_fifo #(.WIDTH(W), .BLKS(BLKS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .blk_nxt(blk_nxt), .blk_run(blk_run),
        .blk_kst(blk_kst), .blk_val(blk_val), .rdy(rdy), .read(read), .skip(skip),
        .str(str), .str_val(str_val), .lvl(lvl), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: committed unread words, one pending (serialising) block, generator state.
    logic [W-1:0] cq[$];
    logic         ser_pend;
    int           ser_due;
    logic [511:0] ser_blk;
    int           epoch;
    int           gen_cnt;
    int           gen_epoch;
    logic [511:0] gen_blk;
    int           cyc;
    int           nxt_cnt;
    int           bad_req;
    logic [W-1:0] exp_str;
    logic         exp_str_val;
    logic         exp_err;
    int           ncmp;
    int           nerr;

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Advance one clock: drive the generator, predict the edge, then land on the next negedge.
    task automatic step();
        int e0, sz, rem, held;
        blk_val = (gen_cnt == 1);
        blk_kst = blk_val ? gen_blk : rand512();
        blk_run = (gen_cnt > 1);
        e0      = epoch;
        sz      = cq.size();
        held    = (sz + WPB - 1) / WPB + (ser_pend ? 1 : 0);
        if (blk_nxt === 1'b1) begin
            nxt_cnt++;
            if (gen_cnt != 0 || held >= BLKS) bad_req++;
        end
        exp_str     = '0;
        exp_str_val = 1'b0;
        exp_err     = 1'b0;
        if (rst || flush) begin
            epoch++;
            cq.delete();
            ser_pend = 1'b0;
        end else begin
            exp_str_val = read && (sz > 0);
            exp_err     = read && (sz == 0);
            if (sz > 0 && (read || skip)) begin
                rem = (sz % WPB == 0) ? WPB : sz % WPB;
                if (read) exp_str = cq[0];
                if (skip) repeat (rem) void'(cq.pop_front());
                else void'(cq.pop_front());
            end
            if (ser_pend && ser_due == cyc) begin
                for (int w = 0; w < WPB; w++) cq.push_back(ser_blk[w*W +: W]);
                ser_pend = 1'b0;
            end
            if (blk_val && gen_epoch == e0) begin
                ser_pend = 1'b1;
                ser_due  = cyc + WPB;
                ser_blk  = gen_blk;
            end
        end
        if (gen_cnt > 0) gen_cnt--;
        if (blk_nxt === 1'b1) begin
            gen_cnt   = GEN_LAT;
            gen_blk   = rand512();
            gen_epoch = e0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        ncmp++; if (blk_nxt !== 1'b0) begin nerr++; $display("FAIL reset_nxt: got %b want 0", blk_nxt); end
        ncmp++; if (rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        ncmp++; if (str !== '0) begin nerr++; $display("FAIL reset_str: got %h want 0", str); end
        ncmp++; if (str_val !== 1'b0) begin nerr++; $display("FAIL reset_sval: got %b want 0", str_val); end
        ncmp++; if (lvl !== '0) begin nerr++; $display("FAIL reset_lvl: got %0d want 0", lvl); end
        ncmp++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int n0;
        n0 = nxt_cnt;
        repeat (150) step();
        ncmp++;
        if (nxt_cnt - n0 != BLKS) begin
            nerr++; $display("FAIL fill_requests: got %0d want %0d", nxt_cnt - n0, BLKS);
        end
        ncmp++;
        if (lvl !== LW'(BLKS * WPB) || cq.size() != BLKS * WPB) begin
            nerr++; $display("FAIL fill_lvl: got %0d want %0d (model %0d)", lvl, BLKS * WPB, cq.size());
        end
    endtask

    task automatic test_stream();
        int n0;
        n0 = nxt_cnt;
        for (int i = 0; i < 32 + 150; i++) begin
            read = (i < 32) ? 1'b1 : rdy;
            step();
            ncmp++;
            if ({str_val, err, rdy, lvl} !== {exp_str_val, exp_err, cq.size() != 0, LW'(cq.size())}) begin
                nerr++;
                $display("FAIL stream_flags: got v=%b e=%b r=%b lvl=%0d want v=%b e=%b lvl=%0d",
                         str_val, err, rdy, lvl, exp_str_val, exp_err, cq.size());
            end
            if (exp_str_val) begin
                ncmp++;
                if (str !== exp_str) begin nerr++; $display("FAIL stream_word: got %h want %h", str, exp_str); end
            end
        end
        read = 1'b0;
        ncmp++;
        if (nxt_cnt - n0 < BLKS) begin
            nerr++; $display("FAIL stream_refill: got %0d requests want >= %0d", nxt_cnt - n0, BLKS);
        end
        ncmp++; if (bad_req != 0) begin nerr++; $display("FAIL over_request: got %0d want 0", bad_req); end
    endtask

    task automatic test_commit_boundary();
        int rise, sv;
        logic [LW-1:0] lvl_rise;
        rise = -1; sv = -1; lvl_rise = '0;
        flush = 1'b1; step(); flush = 1'b0;
        read = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (rise < 0 && rdy === 1'b1) begin rise = i; lvl_rise = lvl; end
            if (sv < 0 && str_val === 1'b1) sv = i;
            ncmp++;
            if ({str_val, err, rdy, lvl} !== {exp_str_val, exp_err, cq.size() != 0, LW'(cq.size())}) begin
                nerr++;
                $display("FAIL commit_flags: got v=%b e=%b r=%b lvl=%0d want v=%b e=%b lvl=%0d",
                         str_val, err, rdy, lvl, exp_str_val, exp_err, cq.size());
            end
        end
        read = 1'b0;
        ncmp++; if (rise < 0 || lvl_rise !== LW'(WPB)) begin
            nerr++; $display("FAIL commit_rdy_lvl: got %0d want %0d", lvl_rise, WPB);
        end
        ncmp++; if (sv != rise + 1) begin
            nerr++; $display("FAIL commit_lag: got str_val at %0d want %0d", sv, rise + 1);
        end
    endtask

    task automatic test_skip();
        logic [W-1:0] w1, b1w0;
        int l0;
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 400 && !(cq.size() >= 24 && !ser_pend); i++) step();
        ncmp++;
        if (!(cq.size() >= 24 && !ser_pend)) begin
            nerr++; $display("FAIL skip_fill_timeout: got lvl %0d want >= 24", cq.size());
        end else begin
            w1 = cq[1]; b1w0 = cq[WPB];
            read = 1'b1; step();
            l0 = cq.size();
            skip = 1'b1; step();
            ncmp++; if (str !== w1) begin nerr++; $display("FAIL skip_word1: got %h want %h", str, w1); end
            ncmp++; if (lvl !== LW'(l0 - 7)) begin
                nerr++; $display("FAIL skip_lvl: got %0d want %0d", lvl, l0 - 7);
            end
            skip = 1'b0; step();
            ncmp++; if (str !== b1w0) begin nerr++; $display("FAIL skip_next_blk: got %h want %h", str, b1w0); end
            read = 1'b0;
            step();
            l0 = cq.size();
            skip = 1'b1; step();
            ncmp++; if (lvl !== LW'(l0 - 7)) begin
                nerr++; $display("FAIL skip_only_lvl: got %0d want %0d", lvl, l0 - 7);
            end
            l0 = cq.size();
            step();
            ncmp++; if (lvl !== LW'(l0 - WPB)) begin
                nerr++; $display("FAIL skip_word0_lvl: got %0d want %0d", lvl, l0 - WPB);
            end
            skip = 1'b0;
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 400 && !(blk_nxt === 1'b1 && cq.size() >= WPB); i++) step();
        ncmp++;
        if (!(blk_nxt === 1'b1 && cq.size() >= WPB)) begin
            nerr++; $display("FAIL flush_wait_timeout: got nxt=%b lvl=%0d want nxt=1", blk_nxt, lvl);
        end
        repeat (5) step();
        flush = 1'b1; step(); flush = 1'b0;
        ncmp++; if (lvl !== '0) begin nerr++; $display("FAIL flush_lvl: got %0d want 0", lvl); end
        ncmp++; if (rdy !== 1'b0) begin nerr++; $display("FAIL flush_rdy: got %b want 0", rdy); end
        ncmp++; if (str_val !== 1'b0) begin nerr++; $display("FAIL flush_sval: got %b want 0", str_val); end
        for (int i = 0; i < 120; i++) begin
            read = (i > 60) ? 1'b1 : 1'b0;
            step();
            ncmp++;
            if ({str_val, err, rdy, lvl} !== {exp_str_val, exp_err, cq.size() != 0, LW'(cq.size())}) begin
                nerr++;
                $display("FAIL flush_flags: got v=%b e=%b r=%b lvl=%0d want v=%b e=%b lvl=%0d",
                         str_val, err, rdy, lvl, exp_str_val, exp_err, cq.size());
            end
            if (exp_str_val) begin
                ncmp++;
                if (str !== exp_str) begin nerr++; $display("FAIL flush_word: got %h want %h", str, exp_str); end
            end
        end
        read = 1'b0;
    endtask

    task automatic test_underflow();
        flush = 1'b1; step(); flush = 1'b0;
        read = 1'b1; step(); read = 1'b0;
        ncmp++; if (err !== 1'b1) begin nerr++; $display("FAIL under_err: got %b want 1", err); end
        ncmp++; if (str_val !== 1'b0) begin nerr++; $display("FAIL under_sval: got %b want 0", str_val); end
        ncmp++; if (str !== '0) begin nerr++; $display("FAIL under_str: got %h want 0", str); end
        ncmp++; if (lvl !== '0) begin nerr++; $display("FAIL under_lvl: got %0d want 0", lvl); end
        step();
        ncmp++; if (err !== 1'b0) begin nerr++; $display("FAIL under_pulse: got %b want 0", err); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            read  = ($urandom_range(0, 1) == 1);
            skip  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 99) == 0);
            step();
            ncmp++;
            if ({str_val, err, rdy, lvl} !== {exp_str_val, exp_err, cq.size() != 0, LW'(cq.size())}) begin
                nerr++;
                $display("FAIL rand_flags: got v=%b e=%b r=%b lvl=%0d want v=%b e=%b lvl=%0d",
                         str_val, err, rdy, lvl, exp_str_val, exp_err, cq.size());
            end
            if (exp_str_val) begin
                ncmp++;
                if (str !== exp_str) begin nerr++; $display("FAIL rand_word: got %h want %h", str, exp_str); end
            end
        end
        read = 1'b0; skip = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 400 && !ser_pend; i++) step();
        ncmp++; if (!ser_pend) begin nerr++; $display("FAIL rmid_timeout: got no block want one"); end
        repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        ncmp++; if ({blk_nxt, rdy, str_val, err} !== 4'b0000) begin
            nerr++; $display("FAIL rmid_flags: got %b want 0000", {blk_nxt, rdy, str_val, err});
        end
        ncmp++; if (lvl !== '0 || str !== '0) begin
            nerr++; $display("FAIL rmid_lvl_str: got lvl=%0d str=%h want 0", lvl, str);
        end
        for (int i = 0; i < 100; i++) begin
            read = (i > 70) ? 1'b1 : 1'b0;
            step();
            ncmp++;
            if ({str_val, err, rdy, lvl} !== {exp_str_val, exp_err, cq.size() != 0, LW'(cq.size())}) begin
                nerr++;
                $display("FAIL rmid_flags2: got v=%b e=%b r=%b lvl=%0d want v=%b e=%b lvl=%0d",
                         str_val, err, rdy, lvl, exp_str_val, exp_err, cq.size());
            end
            if (exp_str_val) begin
                ncmp++;
                if (str !== exp_str) begin nerr++; $display("FAIL rmid_word: got %h want %h", str, exp_str); end
            end
        end
        read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; read = 1'b0; skip = 1'b0;
        blk_val = 1'b0; blk_run = 1'b0; blk_kst = '0;
        ser_pend = 1'b0; ser_due = 0; ser_blk = '0; epoch = 0;
        gen_cnt = 0; gen_epoch = -1; gen_blk = '0; cyc = 0;
        nxt_cnt = 0; bad_req = 0; ncmp = 0; nerr = 0;
        exp_str = '0; exp_str_val = 1'b0; exp_err = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_commit_boundary();
        test_skip();
        test_flush();
        test_underflow();
        test_random();
        test_reset_mid();
        ncmp++; if (bad_req != 0) begin nerr++; $display("FAIL final_over_request: got %0d want 0", bad_req); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
